// File: rtl/fb_cmd_pkg.sv
// Shared definitions for the frame command stream.
// The command encoding is also used by the pattern generators that produce the stream.
// The consumer FSM state type and the skid FIFO depth rule live here as well.
package fb_cmd_pkg;

    typedef enum logic [1:0] {
        FB_CMD_NONE        = 2'd0,
        FB_CMD_FRAME_START = 2'd1,
        FB_CMD_ROW_START   = 2'd2,
        FB_CMD_FRAME_END   = 2'd3
    } fb_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WAIT_ROW,
        ST_FETCH_ROW,
        ST_DRAIN_ROW,
        ST_FRAME_END
    } fcc_state_t;

    // The FIFO must absorb every read already in flight plus one word per cycle of
    // write-port stall, so it is sized from the read latency.
    function automatic int fcc_fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/row_skid_fifo.sv
// Register-based skid FIFO between the line-buffer read pipeline and the
// framebuffer write port.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (pointers/count only)
//   push_i         write push_data_i (ignored when full and not popping)
//   push_data_i    word to store
//   pop_i          remove head word (ignored when empty)
//   head_o         oldest stored word
//   count_o        number of stored words
//   empty_o        count_o == 0
module row_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (!do_push && do_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/frame_command_consumer.sv
// Memory-clock-side consumer of the frame command stream. Accepts FRAME_START /
// ROW_START / FRAME_END commands, fetches each row word-by-word from the producer's
// line buffer (fixed read latency) and streams the words to the SDRAM framebuffer
// write port as a linear, row-major sequence under valid/ready backpressure.
// Ports:
//   clk, reset_n        memory clock, asynchronous active-low reset
//   command_data_valid  producer has a command pending
//   command_data        fb_cmd_t encoded command
//   mem_controller_rdy  one-cycle accept pulse; command_data sampled on that edge
//   mem_addr            line-buffer word address
//   pixel_data          line-buffer word, READ_LATENCY cycles after mem_addr
//   fb_wr_valid/ready   write beat handshake
//   fb_wr_addr/data     beat word address and data
//   frame_done          one-cycle pulse once a frame is closed and fully written
//   protocol_error      sticky command-sequence error flag
module frame_command_consumer
    import fb_cmd_pkg::*;
#(
    parameter int                    FRAME_WIDTH  = 640,
    parameter int                    FRAME_HEIGHT = 480,
    parameter int                    READ_LATENCY = 3,
    parameter int                    ADDR_WIDTH   = 21,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE      = '0,
    localparam int WORDS = FRAME_WIDTH / 2,
    localparam int MAW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  command_data_valid,
    input  logic [1:0]            command_data,
    output logic                  mem_controller_rdy,
    output logic [MAW-1:0]        mem_addr,
    input  logic [31:0]           pixel_data,
    output logic                  fb_wr_valid,
    input  logic                  fb_wr_ready,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [31:0]           fb_wr_data,
    output logic                  frame_done,
    output logic                  protocol_error
);

    localparam int DEPTH = fcc_fifo_depth(READ_LATENCY);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(FRAME_HEIGHT + 1);

    fcc_state_t              state_q, state_d;
    logic                    in_frame_q, in_frame_d;
    logic [RW-1:0]           row_q, row_d;
    logic [MAW-1:0]          issue_q, issue_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                    err_q, err_d;
    logic [READ_LATENCY-1:0] tag_q;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic [31:0]             fifo_head;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    credit;
    logic                    fire;
    fb_cmd_t                 cmd;

    assign cmd = fb_cmd_t'(command_data);

    // Every issued read owns a FIFO slot from issue until it is written out.
    assign credit    = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH);
    assign fire      = (state_q == ST_FETCH_ROW) && credit;
    assign fifo_push = tag_q[READ_LATENCY-1];
    assign fifo_pop  = fb_wr_valid && fb_wr_ready;

    always_comb begin
        inflight_d = inflight_q;
        if (fire && !fifo_push)      inflight_d = inflight_q + CW'(1);
        else if (!fire && fifo_push) inflight_d = inflight_q - CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        row_d      = row_q;
        issue_d    = issue_q;
        err_d      = err_q;
        wr_addr_d  = wr_addr_q;
        if (fifo_pop) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (command_data_valid) begin
                    in_frame_d = 1'b0;
                    state_d    = ST_ACCEPT;
                end
            end
            ST_WAIT_ROW: begin
                if (command_data_valid) begin
                    in_frame_d = 1'b1;
                    state_d    = ST_ACCEPT;
                end
            end
            // The accept pulse is high in this state; the command is decoded on the
            // same edge that the producer sees it taken.
            ST_ACCEPT: begin
                if (!in_frame_q) begin
                    if (cmd == FB_CMD_FRAME_START) begin
                        row_d     = '0;
                        wr_addr_d = FB_BASE;
                        state_d   = ST_WAIT_ROW;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    case (cmd)
                        FB_CMD_ROW_START: begin
                            if (row_q < RW'(FRAME_HEIGHT)) begin
                                issue_d = '0;
                                state_d = ST_FETCH_ROW;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_WAIT_ROW;
                            end
                        end
                        FB_CMD_FRAME_END: begin
                            if (row_q != RW'(FRAME_HEIGHT)) err_d = 1'b1;
                            state_d = ST_FRAME_END;
                        end
                        FB_CMD_FRAME_START: begin
                            err_d     = 1'b1;
                            row_d     = '0;
                            wr_addr_d = FB_BASE;
                            state_d   = ST_WAIT_ROW;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_WAIT_ROW;
                        end
                    endcase
                end
            end
            ST_FETCH_ROW: begin
                if (fire) begin
                    if (issue_q == MAW'(WORDS - 1)) begin
                        issue_d = '0;
                        state_d = ST_DRAIN_ROW;
                    end else begin
                        issue_d = issue_q + MAW'(1);
                    end
                end
            end
            ST_DRAIN_ROW: begin
                if ((inflight_q == '0) && fifo_empty) begin
                    row_d   = row_q + RW'(1);
                    state_d = ST_WAIT_ROW;
                end
            end
            ST_FRAME_END: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            in_frame_q <= 1'b0;
            row_q      <= '0;
            issue_q    <= '0;
            wr_addr_q  <= FB_BASE;
            err_q      <= 1'b0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            row_q      <= row_d;
            issue_q    <= issue_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            // Tag bit i marks that the read issued i+1 cycles ago is valid.
            tag_q[0]   <= fire;
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    row_skid_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (pixel_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign mem_controller_rdy = (state_q == ST_ACCEPT);
    assign mem_addr           = issue_q;
    assign fb_wr_valid        = !fifo_empty;
    assign fb_wr_addr         = wr_addr_q;
    // FIFO storage is not reset, so the data bus is forced to zero when nothing is valid.
    assign fb_wr_data         = fifo_empty ? 32'd0 : fifo_head;
    assign frame_done         = (state_q == ST_FRAME_END) && fifo_empty;
    assign protocol_error     = err_q;

endmodule

// File: tb/tb_frame_command_consumer.sv
module tb_frame_command_consumer;
    import fb_cmd_pkg::*;

    localparam int AW    = 21;
    localparam int WORDS = 320;
    localparam logic [AW-1:0] BASE0 = 21'h000000;
    localparam logic [AW-1:0] BASE1 = 21'h1FFF9C;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          cmd_valid;
    logic [1:0]    cmd_data;
    logic          ready;
    logic          sel;
    int            ready_mode;

    logic          rdy0, rdy1, v0, v1, done0, done1, err0, err1;
    logic [8:0]    maddr0, maddr1;
    logic [31:0]   pix0, pix1, d0, d1;
    logic [AW-1:0] a0, a1;

    logic          rdy, v, done;
    logic [AW-1:0] a;
    logic [31:0]   d;
    assign rdy  = sel ? rdy1 : rdy0;
    assign v    = sel ? v1 : v0;
    assign done = sel ? done1 : done0;
    assign a    = sel ? a1 : a0;
    assign d    = sel ? d1 : d0;

    frame_command_consumer #(
        .FRAME_WIDTH(640), .FRAME_HEIGHT(4), .READ_LATENCY(3), .ADDR_WIDTH(AW), .FB_BASE(BASE0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .command_data_valid(cmd_valid && !sel),
        .command_data(cmd_data), .mem_controller_rdy(rdy0), .mem_addr(maddr0),
        .pixel_data(pix0), .fb_wr_valid(v0), .fb_wr_ready(ready), .fb_wr_addr(a0),
        .fb_wr_data(d0), .frame_done(done0), .protocol_error(err0)
    );

    frame_command_consumer #(
        .FRAME_WIDTH(640), .FRAME_HEIGHT(4), .READ_LATENCY(6), .ADDR_WIDTH(AW), .FB_BASE(BASE1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .command_data_valid(cmd_valid && sel),
        .command_data(cmd_data), .mem_controller_rdy(rdy1), .mem_addr(maddr1),
        .pixel_data(pix1), .fb_wr_valid(v1), .fb_wr_ready(ready), .fb_wr_addr(a1),
        .fb_wr_data(d1), .frame_done(done1), .protocol_error(err1)
    );

    // Line-buffer model: the word for an address appears READ_LATENCY clocks later.
    int         cur_frame, cur_row, next_row;
    logic [8:0] p0 [3];
    logic [8:0] p1 [6];

    function automatic logic [31:0] pix(input int f, input int r, input logic [8:0] k);
        return {f[7:0], r[7:0], 7'd0, k} ^ 32'hC3A5_0F1E;
    endfunction

    always @(posedge clk) begin
        p0[0] <= maddr0;
        for (int i = 1; i < 3; i++) p0[i] <= p0[i-1];
        p1[0] <= maddr1;
        for (int i = 1; i < 6; i++) p1[i] <= p1[i-1];
    end
    assign pix0 = pix(cur_frame, cur_row, p0[2]);
    assign pix1 = pix(cur_frame, cur_row, p1[5]);

    int            tests, fails, beats, done_cnt, ovf_cnt;
    beat_t         sbq[$];
    logic          got_first;
    logic [AW-1:0] first_addr;
    logic          hold_prev, rdy_prev;
    logic [AW-1:0] pa;
    logic [31:0]   pd;
    logic [AW-1:0] exp_addr;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ready = ($urandom_range(0, 1) == 1);
                2:       ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'b1;
            endcase
        end
    end

    // Write-port monitor and scoreboard consumer.
    always @(negedge clk) begin
        beat_t e;
        if (reset_n) begin
            if (done) done_cnt++;
            if (rdy) begin
                tests++;
                if (rdy_prev) begin
                    fails++;
                    $display("FAIL rdy_consecutive: rdy high %0d cycles in a row, required 1", 2);
                end
            end
            if (hold_prev) begin
                tests++;
                if (v !== 1'b1 || a !== pa || d !== pd) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b a=%h d=%h, required v=1 a=%h d=%h", v, a, d, pa, pd);
                end
            end
            if (v && ready) begin
                beats++;
                if (!got_first) begin
                    first_addr = a;
                    got_first  = 1'b1;
                end
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got a=%h d=%h, required no beat", a, d);
                end else begin
                    e = sbq.pop_front();
                    if (a !== e.a || d !== e.d) begin
                        fails++;
                        $display("FAIL beat_data: got a=%h d=%h, required a=%h d=%h", a, d, e.a, e.d);
                    end
                end
            end
            hold_prev = v && !ready;
            pa        = a;
            pd        = d;
            rdy_prev  = rdy;
        end else begin
            hold_prev = 1'b0;
            rdy_prev  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (dut0.fifo_push && !dut0.fifo_pop && dut0.fifo_count == 5) ovf_cnt++;
            if (dut1.fifo_push && !dut1.fifo_pop && dut1.fifo_count == 8) ovf_cnt++;
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic send_cmd(input fb_cmd_t code);
        int n;
        n = 0;
        cmd_data  = code;
        cmd_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (rdy) begin
                if (code == FB_CMD_ROW_START) begin
                    cur_row  = next_row;
                    next_row = next_row + 1;
                end
                break;
            end
            n++;
            if (n > 5000) begin
                tests++;
                fails++;
                $display("FAIL cmd_timeout: got no accept in %0d cycles, required accept of code %0d", n, code);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 2'd0;
    endtask

    task automatic run_frame(input int nrows, input bit do_end, input int fid);
        cur_frame = fid;
        next_row  = 0;
        exp_addr  = sel ? BASE1 : BASE0;
        send_cmd(FB_CMD_FRAME_START);
        for (int r = 0; r < nrows; r++) begin
            for (int k = 0; k < WORDS; k++) begin
                sbq.push_back('{a: exp_addr, d: pix(fid, r, 9'(k))});
                exp_addr = exp_addr + 21'd1;
            end
            send_cmd(FB_CMD_ROW_START);
        end
        if (do_end) send_cmd(FB_CMD_FRAME_END);
    endtask

    task automatic wait_drain(input int exp_done, input int budget);
        int n;
        n = 0;
        while (!(sbq.size() == 0 && done_cnt >= exp_done)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: got %0d beats left and %0d done, required 0 left and %0d done",
                         sbq.size(), done_cnt, exp_done);
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_counts();
        beats     = 0;
        done_cnt  = 0;
        got_first = 1'b0;
    endtask

    task automatic test_reset();
        sel       = 1'b0;
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = FB_CMD_FRAME_START;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b required 0", rdy0); end
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", v0); end
        tests++; if (a0 !== BASE0) begin fails++; $display("FAIL reset_addr: got %h required %h", a0, BASE0); end
        tests++; if (d0 !== 32'd0) begin fails++; $display("FAIL reset_data: got %h required 0", d0); end
        tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err0); end
        tests++; if (maddr0 !== 9'd0) begin fails++; $display("FAIL reset_mem_addr: got %h required 0", maddr0); end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_full_frame();
        clear_counts();
        ready_mode = 0;
        run_frame(4, 1'b1, 1);
        wait_drain(1, 5000);
        tests++; if (beats != 1280) begin fails++; $display("FAIL full_beats: got %0d required 1280", beats); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done: got %0d required 1", done_cnt); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL full_err: got %b required 0", err0); end
        tests++; if (first_addr !== BASE0) begin fails++; $display("FAIL full_first_addr: got %h required %h", first_addr, BASE0); end
        tests++; if (a0 !== 21'd1280) begin fails++; $display("FAIL full_end_addr: got %h required %h", a0, 21'd1280); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        clear_counts();
        ready_mode = 1;
        run_frame(4, 1'b1, 2);
        wait_drain(1, 10000);
        ready_mode = 0;
        tests++; if (beats != 1280) begin fails++; $display("FAIL bp_beats: got %0d required 1280", beats); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL bp_err: got %b required 0", err0); end
    endtask

    task automatic test_bad_first_cmd();
        apply_reset();
        clear_counts();
        send_cmd(FB_CMD_ROW_START);
        repeat (20) @(negedge clk);
        tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL badcmd_err: got %b required 1", err0); end
        tests++; if (beats != 0) begin fails++; $display("FAIL badcmd_beats: got %0d required 0", beats); end
        tests++; if (dut0.state_q !== ST_IDLE) begin fails++; $display("FAIL badcmd_state: got %0d required %0d", dut0.state_q, ST_IDLE); end
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL badcmd_done: got %0d required 0", done_cnt); end
    endtask

    task automatic test_short_frame();
        apply_reset();
        clear_counts();
        run_frame(3, 1'b1, 5);
        wait_drain(1, 5000);
        tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL short_err: got %b required 1", err0); end
        tests++; if (beats != 960) begin fails++; $display("FAIL short_beats: got %0d required 960", beats); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL short_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_row();
        int n;
        apply_reset();
        clear_counts();
        run_frame(3, 1'b0, 6);
        n = 0;
        while (beats < 740 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tests++; if (beats < 740) begin fails++; $display("FAIL midrow_progress: got %0d beats required >= 740", beats); end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL midrow_rst_valid: got %b required 0", v0); end
        tests++; if (maddr0 !== 9'd0) begin fails++; $display("FAIL midrow_rst_mem_addr: got %h required 0", maddr0); end
        tests++; if (d0 !== 32'd0) begin fails++; $display("FAIL midrow_rst_data: got %h required 0", d0); end
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL midrow_rst_rdy: got %b required 0", rdy0); end
        sbq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_counts();
        run_frame(4, 1'b1, 7);
        wait_drain(1, 5000);
        tests++; if (first_addr !== BASE0) begin fails++; $display("FAIL midrow_first_addr: got %h required %h", first_addr, BASE0); end
        tests++; if (beats != 1280) begin fails++; $display("FAIL midrow_beats: got %0d required 1280", beats); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL midrow_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] end_addr;
        apply_reset();
        sel = 1'b1;
        clear_counts();
        ready_mode = 2;
        for (int f = 0; f < 20; f++) run_frame(4, 1'b1, 10 + f);
        wait_drain(20, 60000);
        ready_mode = 0;
        end_addr = BASE1 + 21'd1280;
        tests++; if (beats != 25600) begin fails++; $display("FAIL b2b_beats: got %0d required 25600", beats); end
        tests++; if (done_cnt != 20) begin fails++; $display("FAIL b2b_done: got %0d required 20", done_cnt); end
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL b2b_err: got %b required 0", err1); end
        tests++; if (first_addr !== BASE1) begin fails++; $display("FAIL b2b_first_addr: got %h required %h", first_addr, BASE1); end
        tests++; if (a1 !== end_addr) begin fails++; $display("FAIL b2b_wrap_addr: got %h required %h", a1, end_addr); end
        sel = 1'b0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        ovf_cnt    = 0;
        ready      = 1'b1;
        ready_mode = 0;
        cmd_data   = 2'd0;
        cmd_valid  = 1'b0;
        cur_frame  = 0;
        cur_row    = 0;
        next_row   = 0;
        hold_prev  = 1'b0;
        rdy_prev   = 1'b0;
        clear_counts();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_bad_first_cmd();
        test_short_frame();
        test_reset_mid_row();
        test_back_to_back();
        tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL fifo_overflow: got %0d overflow events required 0", ovf_cnt); end
        tests++; if (sbq.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d required 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
